// File: rtl/pipe_skid_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_chain
// Elastic DEPTH-stage valid/ready pipeline built from 2-entry skid buffers,
// with synchronous flush and a registered occupancy count.
// Revision : 1.0
// ============================================================================
module pipe_skid_chain #(
    parameter  int WIDTH      = 32,
    parameter  int DEPTH      = 1,
    parameter  bit CLEAR_DATA = 1'b1,
    localparam int CW         = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic             w_up_valid [DEPTH];
    logic [WIDTH-1:0] w_up_data  [DEPTH];
    logic             w_dn_ready [DEPTH];
    logic             w_m_valid  [DEPTH];
    logic [WIDTH-1:0] w_m_data   [DEPTH];
    logic             w_s_valid  [DEPTH];

    logic             w_in_fire;
    logic             w_out_fire;
    logic [CW-1:0]    r_count;

    // in_ready looks only at stage-0 skid state and flush, never at out_ready.
    assign in_ready   = ~w_s_valid[0] & ~flush;
    assign out_valid  = w_m_valid[DEPTH-1] & ~flush;
    assign out_data   = w_m_data[DEPTH-1];
    assign count      = r_count;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic             r_m_valid;
            logic             r_s_valid;
            logic [WIDTH-1:0] r_m_data;
            logic [WIDTH-1:0] r_s_data;
            logic             w_take;
            logic             w_give;

            if (k == 0) begin : g_head
                assign w_up_valid[k] = in_valid;
                assign w_up_data[k]  = in_data;
            end else begin : g_link
                assign w_up_valid[k] = w_m_valid[k-1];
                assign w_up_data[k]  = w_m_data[k-1];
            end

            if (k == DEPTH-1) begin : g_tail
                assign w_dn_ready[k] = out_ready;
            end else begin : g_body
                assign w_dn_ready[k] = ~w_s_valid[k+1];
            end

            assign w_take       = w_up_valid[k] & ~r_s_valid;
            assign w_give       = r_m_valid & w_dn_ready[k];
            assign w_m_valid[k] = r_m_valid;
            assign w_m_data[k]  = r_m_data;
            assign w_s_valid[k] = r_s_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_m_valid <= 1'b0;
                    r_s_valid <= 1'b0;
                    r_m_data  <= '0;
                    r_s_data  <= '0;
                end else if (flush) begin
                    r_m_valid <= 1'b0;
                    r_s_valid <= 1'b0;
                    if (CLEAR_DATA) begin
                        r_m_data <= '0;
                        r_s_data <= '0;
                    end
                end else if (w_give) begin
                    // Skid entry is older than anything arriving, so it moves up first.
                    if (r_s_valid) begin
                        r_m_data  <= r_s_data;
                        r_s_valid <= 1'b0;
                    end else if (w_take) begin
                        r_m_data  <= w_up_data[k];
                    end else begin
                        r_m_valid <= 1'b0;
                    end
                end else if (w_take) begin
                    if (r_m_valid) begin
                        r_s_data  <= w_up_data[k];
                        r_s_valid <= 1'b1;
                    end else begin
                        r_m_data  <= w_up_data[k];
                        r_m_valid <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_count <= r_count + CW'(1);
        end else if (!w_in_fire && w_out_fire) begin
            r_count <= r_count - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_chain.sv
`default_nettype none
// Testbench for pipe_skid_chain: three configurations driven against a
// queue-based reference of FIFO order, latency and capacity.
module tb_pipe_skid_chain;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: DEPTH=3, CLEAR_DATA=1
    logic         a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [W-1:0] a_in_data, a_out_data;
    logic [2:0]   a_count;
    // Instance B: DEPTH=2, CLEAR_DATA=1
    logic         b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [W-1:0] b_in_data, b_out_data;
    logic [2:0]   b_count;
    // Instance C: DEPTH=4, CLEAR_DATA=0
    logic         c_reset, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [W-1:0] c_in_data, c_out_data;
    logic [3:0]   c_count;

    pipe_skid_chain #(.WIDTH(W), .DEPTH(3), .CLEAR_DATA(1'b1)) u_a (
        .clk(clk), .reset(a_reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    pipe_skid_chain #(.WIDTH(W), .DEPTH(2), .CLEAR_DATA(1'b1)) u_b (
        .clk(clk), .reset(b_reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
    );

    pipe_skid_chain #(.WIDTH(W), .DEPTH(4), .CLEAR_DATA(1'b0)) u_c (
        .clk(clk), .reset(c_reset), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .count(c_count)
    );

    task automatic test_reset();
        @(negedge clk);
        a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        a_reset = 1'b0;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        n_cmp++; if (a_out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got=%h exp=00", a_out_data); end
        n_cmp++; if (a_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", a_count); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] qv[$];
        int           qt[$];
        int           nxt = 1;
        int           got = 0;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            a_in_valid = (nxt <= 10);
            a_in_data  = W'(nxt);
            #1;
            if (a_out_valid) begin
                n_cmp++;
                if (qv.size() == 0) begin
                    n_err++; $display("FAIL stream_spurious cyc=%0d got=%h exp=none", cyc, a_out_data);
                end else begin
                    if (a_out_data !== qv[0] || cyc - qt[0] != 3) begin
                        n_err++;
                        $display("FAIL stream_data cyc=%0d got=%h lat=%0d exp=%h lat=3", cyc, a_out_data, cyc - qt[0], qv[0]);
                    end
                    void'(qv.pop_front()); void'(qt.pop_front());
                    got++;
                end
            end
            if (cyc >= 3 && cyc <= 10) begin
                n_cmp++; if (a_count !== 3'd3) begin n_err++; $display("FAIL stream_count cyc=%0d got=%0d exp=3", cyc, a_count); end
            end
            if (a_in_valid && a_in_ready) begin
                qv.push_back(a_in_data); qt.push_back(cyc); nxt++;
            end
        end
        @(negedge clk); a_in_valid = 1'b0;
        n_cmp++; if (got != 10) begin n_err++; $display("FAIL stream_total got=%0d exp=10", got); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int nxt = 'h10;
        int exp = 'h10;
        b_out_ready = 1'b0; b_flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1; b_in_data = W'(nxt);
            #1;
            if (b_in_ready) begin acc++; nxt++; end
        end
        @(negedge clk); b_in_valid = 1'b0; #1;
        n_cmp++; if (acc != 4) begin n_err++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
        n_cmp++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full got=%b exp=0", b_in_ready); end
        n_cmp++; if (b_count !== 3'd4) begin n_err++; $display("FAIL bp_count_full got=%0d exp=4", b_count); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); b_out_ready = 1'b1; #1;
            if (b_out_valid) begin
                n_cmp++;
                if (b_out_data !== W'(exp)) begin n_err++; $display("FAIL bp_drain_data got=%h exp=%h", b_out_data, W'(exp)); end
                exp++;
            end
        end
        n_cmp++; if (exp != 'h14) begin n_err++; $display("FAIL bp_drain_total got=%0d exp=4", exp - 'h10); end
        n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_drained got=%b exp=1", b_in_ready); end
        n_cmp++; if (b_count !== 3'd0) begin n_err++; $display("FAIL bp_count_drained got=%0d exp=0", b_count); end
    endtask

    task automatic test_flush();
        int acc = 0;
        b_out_ready = 1'b0;
        for (int i = 0; i < 10 && acc < 3; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1; b_in_data = W'('h20 + acc);
            #1;
            if (b_in_ready) acc++;
        end
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = 8'h55; b_out_ready = 1'b1; b_flush = 1'b1;
        #1;
        n_cmp++; if (b_count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got=%0d exp=3", b_count); end
        n_cmp++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b exp=0", b_in_ready); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got=%b exp=0", b_out_valid); end
        @(negedge clk);
        b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 8'hAA;
        #1;
        n_cmp++; if (b_count !== 3'd0) begin n_err++; $display("FAIL flush_post_count got=%0d exp=0", b_count); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_post_valid got=%b exp=0", b_out_valid); end
        n_cmp++; if (b_out_data !== 8'h00) begin n_err++; $display("FAIL flush_post_data got=%h exp=00", b_out_data); end
        n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_post_ready got=%b exp=1", b_in_ready); end
        @(negedge clk); b_in_valid = 1'b0; #1;
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_aa_early got=%b exp=0", b_out_valid); end
        @(negedge clk); #1;
        n_cmp++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'hAA) begin
            n_err++; $display("FAIL flush_aa_out got=%b/%h exp=1/aa", b_out_valid, b_out_data);
        end
        @(negedge clk); b_out_ready = 1'b1;
    endtask

    task automatic test_reset_vs_flush();
        int acc = 0;
        c_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c_in_valid = 1'b1; c_in_data = W'('h80 + i + 1);
            #1;
            if (c_in_ready) acc++;
        end
        @(negedge clk);
        c_in_valid = 1'b1; c_reset = 1'b1; c_flush = 1'b1;
        #1;
        n_cmp++; if (c_count !== 4'(acc)) begin n_err++; $display("FAIL rvf_pre_count got=%0d exp=%0d", c_count, acc); end
        n_cmp++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL rvf_out_valid_during got=%b exp=0", c_out_valid); end
        @(negedge clk);
        c_reset = 1'b0; c_flush = 1'b0; c_in_valid = 1'b0;
        #1;
        n_cmp++; if (c_count !== 4'd0) begin n_err++; $display("FAIL rvf_count got=%0d exp=0", c_count); end
        n_cmp++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL rvf_out_valid got=%b exp=0", c_out_valid); end
        n_cmp++; if (c_out_data !== 8'h00) begin n_err++; $display("FAIL rvf_out_data got=%h exp=00", c_out_data); end
        n_cmp++; if (c_in_ready !== 1'b1) begin n_err++; $display("FAIL rvf_in_ready got=%b exp=1", c_in_ready); end
    endtask

    task automatic test_random_stall();
        logic [W-1:0] q[$];
        int           pin = 50;
        int           pout = 50;
        logic         ro, rdy_a, rdy_b;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                pin  = $urandom_range(20, 95);
                pout = $urandom_range(10, 95);
            end
            @(negedge clk);
            c_in_valid = ($urandom_range(0, 99) < pin);
            c_in_data  = W'($urandom);
            ro         = ($urandom_range(0, 99) < pout);
            c_out_ready = ro;  #1; rdy_a = c_in_ready;
            c_out_ready = !ro; #1; rdy_b = c_in_ready;
            c_out_ready = ro;  #1;
            n_cmp++; if (rdy_a !== rdy_b) begin n_err++; $display("FAIL rnd_ready_comb cyc=%0d got=%b/%b exp=equal", i, rdy_a, rdy_b); end
            n_cmp++; if (c_count !== 4'(q.size())) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, c_count, q.size()); end
            if (q.size() == 8) begin
                n_cmp++; if (c_in_ready !== 1'b0) begin n_err++; $display("FAIL rnd_overfill cyc=%0d got=%b exp=0", i, c_in_ready); end
            end
            if (c_out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious cyc=%0d got=%h exp=none", i, c_out_data);
                end else if (c_out_data !== q[0]) begin
                    n_err++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, c_out_data, q[0]);
                end
                if (c_out_ready && q.size() > 0) void'(q.pop_front());
            end
            if (c_in_valid && c_in_ready) q.push_back(c_in_data);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); c_in_valid = 1'b0; c_out_ready = 1'b1; #1;
            if (c_out_valid) begin
                n_cmp++;
                if (q.size() == 0 || c_out_data !== q[0]) begin
                    n_err++; $display("FAIL rnd_drain_data got=%h exp_left=%0d", c_out_data, q.size());
                end
                if (q.size() > 0) void'(q.pop_front());
            end
        end
        n_cmp++; if (q.size() != 0 || c_count !== 4'd0) begin n_err++; $display("FAIL rnd_drain_end got=%0d left=%0d exp=0", c_count, q.size()); end
    endtask

    initial begin
        a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        c_reset = 1'b1; c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0;
        repeat (2) @(negedge clk);
        b_reset = 1'b0; c_reset = 1'b0;

        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_vs_flush();
        test_random_stall();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
